// File: rtl/avmm_bridge_pkg.sv
// Shared types and constants for the Avalon-MM skid bridge.
package avmm_bridge_pkg;

  localparam int unsigned AVMM_ADDR_W  = 26;
  localparam int unsigned AVMM_DATA_W  = 512;
  localparam int unsigned AVMM_BE_W    = AVMM_DATA_W / 8;
  localparam int unsigned AVMM_BURST_W = 12;

  // Avalon response codes, passed through the bridge unmodified.
  localparam logic [1:0] RSP_OKAY   = 2'b00;
  localparam logic [1:0] RSP_SLVERR = 2'b10;
  localparam logic [1:0] RSP_DECERR = 2'b11;

  // One upstream command as it travels through the skid buffer.
  typedef struct packed {
    logic [AVMM_ADDR_W-1:0]  addr;
    logic [AVMM_DATA_W-1:0]  wdata;
    logic [AVMM_BE_W-1:0]    be;
    logic [AVMM_BURST_W-1:0] burst;
    logic                    rd;
    logic                    wr;
  } t_avmm_cmd;

endpackage

// File: rtl/avmm_skid_buf.sv
// Two-entry valid/ready skid buffer over t_avmm_cmd. The main register
// drives the output; the skid register absorbs a push that lands while the
// main register is stalled. Order is strictly FIFO.
module avmm_skid_buf
  import avmm_bridge_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,           // caller guarantees no push while skid is full
  input  t_avmm_cmd data_i,
  input  logic      ready_i,          // downstream can take the main entry
  output logic      valid_o,
  output t_avmm_cmd data_o,
  output logic      skid_full_next_o  // skid register will hold an entry after this edge
);

  logic      main_valid_q, main_valid_d;
  logic      skid_valid_q, skid_valid_d;
  t_avmm_cmd main_q, main_d;
  t_avmm_cmd skid_q, skid_d;
  logic      pop;

  assign pop = main_valid_q & ready_i;

  // Next-state: retire main, promote skid into main, then place a new push.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;

    if (pop) main_valid_d = 1'b0;

    if (skid_valid_q && !main_valid_d) begin
      main_valid_d = 1'b1;
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end

    if (push_i) begin
      if (!main_valid_d) begin
        main_valid_d = 1'b1;
        main_d       = data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_d       = data_i;
      end
    end
  end

  // Control and the output-facing main register; main resets so m_* read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
    end
  end

  // Skid payload register.
  // NOTE: payload is qualified by skid_valid_q, so it needs no reset and stays a plain wide register.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign valid_o          = main_valid_q;
  assign data_o           = main_q;
  assign skid_full_next_o = skid_valid_d;

endmodule

// File: rtl/avmm_skid_bridge.sv
// Avalon-MM pipeline bridge: registered command path through a 2-entry skid
// buffer, registered response path, outstanding read-beat / write-response
// tracking with a read-beat limit and a sticky unexpected-response flag.
// ADDR_W/DATA_W/BURST_W must match the widths of t_avmm_cmd in the package.
module avmm_skid_bridge
  import avmm_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W       = AVMM_ADDR_W,
  parameter int unsigned DATA_W       = AVMM_DATA_W,
  parameter int unsigned BURST_W      = AVMM_BURST_W,
  parameter int unsigned MAX_BURST    = 1,
  parameter int unsigned MAX_RD_BEATS = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                Clk_400,
  input  logic                SoftReset_n,
  input  logic [ADDR_W-1:0]   s_address,
  input  logic [DATA_W-1:0]   s_writedata,
  input  logic [DATA_W/8-1:0] s_byteenable,
  input  logic [BURST_W-1:0]  s_burstcount,
  input  logic                s_read,
  input  logic                s_write,
  output logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_readdata,
  output logic                s_readdatavalid,
  output logic                s_writeresponsevalid,
  output logic [1:0]          s_response,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_writedata,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [BURST_W-1:0]  m_burstcount,
  output logic                m_read,
  output logic                m_write,
  input  logic                m_waitrequest,
  input  logic [DATA_W-1:0]   m_readdata,
  input  logic                m_readdatavalid,
  input  logic                m_writeresponsevalid,
  input  logic [1:0]          m_response,
  output logic [CNT_W-1:0]    rd_pending,
  output logic [CNT_W-1:0]    wr_pending,
  input  logic                clr_err,
  output logic                err_unexpected_rsp
);

  localparam logic [CNT_W-1:0] RD_LIMIT = CNT_W'(MAX_RD_BEATS - MAX_BURST);

  logic             accept;
  logic             skid_full_next;
  logic             cmd_valid;
  t_avmm_cmd        cmd_in, cmd_out;
  logic             s_waitrequest_q, s_waitrequest_d;
  logic [CNT_W-1:0] rd_pending_q, rd_pending_d;
  logic [CNT_W-1:0] wr_pending_q, wr_pending_d;
  logic             err_q, err_d;
  logic             rd_err, wr_err;
  logic [DATA_W-1:0] s_readdata_q;
  logic             s_readdatavalid_q, s_writeresponsevalid_q;
  logic [1:0]       s_response_q;

  assign accept = (s_read | s_write) & ~s_waitrequest_q;

  assign cmd_in = '{addr: s_address, wdata: s_writedata, be: s_byteenable,
                    burst: s_burstcount, rd: s_read, wr: s_write};

  avmm_skid_buf u_skid_buf (
    .clk              (Clk_400),
    .rst_n            (SoftReset_n),
    .push_i           (accept),
    .data_i           (cmd_in),
    .ready_i          (~m_waitrequest),
    .valid_o          (cmd_valid),
    .data_o           (cmd_out),
    .skid_full_next_o (skid_full_next)
  );

  assign m_address    = cmd_out.addr;
  assign m_writedata  = cmd_out.wdata;
  assign m_byteenable = cmd_out.be;
  assign m_burstcount = cmd_out.burst;
  assign m_read       = cmd_valid & cmd_out.rd;
  assign m_write      = cmd_valid & cmd_out.wr;

  // Pending counters, underflow detection, sticky error and upstream stall.
  always_comb begin
    rd_err = m_readdatavalid & (rd_pending_q == '0);
    wr_err = m_writeresponsevalid & (wr_pending_q == '0);

    rd_pending_d = rd_pending_q;
    if (accept && s_read)            rd_pending_d = rd_pending_d + CNT_W'(s_burstcount);
    if (m_readdatavalid && !rd_err)  rd_pending_d = rd_pending_d - 1'b1;

    wr_pending_d = wr_pending_q;
    if (accept && s_write)                wr_pending_d = wr_pending_d + 1'b1;
    if (m_writeresponsevalid && !wr_err)  wr_pending_d = wr_pending_d - 1'b1;

    err_d = err_q;
    if (clr_err)         err_d = 1'b0;
    if (rd_err || wr_err) err_d = 1'b1;

    s_waitrequest_d = skid_full_next | (rd_pending_d > RD_LIMIT);
  end

  // Tracking state; stall comes out of reset high and drops on the first edge.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      s_waitrequest_q <= 1'b1;
      rd_pending_q    <= '0;
      wr_pending_q    <= '0;
      err_q           <= 1'b0;
    end else begin
      s_waitrequest_q <= s_waitrequest_d;
      rd_pending_q    <= rd_pending_d;
      wr_pending_q    <= wr_pending_d;
      err_q           <= err_d;
    end
  end

  // Response path: slave responses delayed one cycle; read data holds when idle.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      s_readdata_q           <= '0;
      s_readdatavalid_q      <= 1'b0;
      s_writeresponsevalid_q <= 1'b0;
      s_response_q           <= RSP_OKAY;
    end else begin
      if (m_readdatavalid) s_readdata_q <= m_readdata;
      s_readdatavalid_q      <= m_readdatavalid;
      s_writeresponsevalid_q <= m_writeresponsevalid;
      s_response_q           <= m_response;
    end
  end

  assign s_waitrequest        = s_waitrequest_q;
  assign s_readdata           = s_readdata_q;
  assign s_readdatavalid      = s_readdatavalid_q;
  assign s_writeresponsevalid = s_writeresponsevalid_q;
  assign s_response           = s_response_q;
  assign rd_pending           = rd_pending_q;
  assign wr_pending           = wr_pending_q;
  assign err_unexpected_rsp   = err_q;

endmodule

// File: tb/tb_avmm_skid_bridge.sv
// Testbench for avmm_skid_bridge: directed scenarios plus randomized traffic,
// all checked against a queue/counter reference model of the bridge.
module tb_avmm_skid_bridge;
  import avmm_bridge_pkg::*;

  localparam int ADDR_W       = 26;
  localparam int DATA_W       = 512;
  localparam int BE_W         = DATA_W / 8;
  localparam int BURST_W      = 12;
  localparam int MAX_BURST    = 1;
  localparam int MAX_RD_BEATS = 64;
  localparam int CNT_W        = 8;
  localparam int LIMIT        = MAX_RD_BEATS - MAX_BURST;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [ADDR_W-1:0]   s_address = '0;
  logic [DATA_W-1:0]   s_writedata = '0;
  logic [BE_W-1:0]     s_byteenable = '0;
  logic [BURST_W-1:0]  s_burstcount = '0;
  logic                s_read = 1'b0, s_write = 1'b0;
  logic                s_waitrequest;
  logic [DATA_W-1:0]   s_readdata;
  logic                s_readdatavalid, s_writeresponsevalid;
  logic [1:0]          s_response;
  logic [ADDR_W-1:0]   m_address;
  logic [DATA_W-1:0]   m_writedata;
  logic [BE_W-1:0]     m_byteenable;
  logic [BURST_W-1:0]  m_burstcount;
  logic                m_read, m_write;
  logic                m_waitrequest = 1'b0;
  logic [DATA_W-1:0]   m_readdata = '0;
  logic                m_readdatavalid = 1'b0, m_writeresponsevalid = 1'b0;
  logic [1:0]          m_response = 2'b00;
  logic [CNT_W-1:0]    rd_pending, wr_pending;
  logic                clr_err = 1'b0;
  logic                err_unexpected_rsp;

  always #5 clk = ~clk;

  avmm_skid_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .MAX_BURST(MAX_BURST),
    .MAX_RD_BEATS(MAX_RD_BEATS), .CNT_W(CNT_W)
  ) dut (
    .Clk_400(clk), .SoftReset_n(rst_n),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_burstcount(s_burstcount), .s_read(s_read), .s_write(s_write),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_writeresponsevalid(s_writeresponsevalid), .s_response(s_response),
    .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_burstcount(m_burstcount), .m_read(m_read), .m_write(m_write),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_writeresponsevalid(m_writeresponsevalid), .m_response(m_response),
    .rd_pending(rd_pending), .wr_pending(wr_pending),
    .clr_err(clr_err), .err_unexpected_rsp(err_unexpected_rsp)
  );

  // Reference model: the bridge is an ordered queue of accepted, not yet issued commands.
  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [BE_W-1:0]    be;
    logic [BURST_W-1:0] burst;
    logic               rd;
    logic               wr;
  } cmd_t;

  cmd_t              exp_q[$];
  logic [ADDR_W-1:0] issued_log[$];
  int                rd_m, wr_m;
  logic              err_m;
  logic              exp_rdv, exp_wrv;
  logic [1:0]        exp_rsp;
  logic [DATA_W-1:0] exp_rdata;
  logic              last_acc;
  int                total = 0;
  int                bad = 0;

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    rd_m = 0; wr_m = 0; err_m = 1'b0;
    exp_rdv = 1'b0; exp_wrv = 1'b0; exp_rsp = 2'b00; exp_rdata = '0;
  endfunction

  task automatic idle();
    s_read = 1'b0; s_write = 1'b0;
    m_readdatavalid = 1'b0; m_writeresponsevalid = 1'b0; clr_err = 1'b0;
  endtask

  task automatic drive_cmd(input logic rd, input logic [ADDR_W-1:0] addr);
    s_read = rd; s_write = ~rd; s_address = addr;
    s_writedata = rand_data(); s_byteenable = BE_W'({$urandom, $urandom});
    s_burstcount = BURST_W'(1);
  endtask

  // One clock: predict the edge from current inputs, advance, then compare DUT to model.
  task automatic tick();
    logic acc, iss;
    int   rd_n, wr_n;
    cmd_t c;
    acc = (s_read || s_write) && !s_waitrequest;
    iss = (m_read || m_write) && !m_waitrequest;
    last_acc = acc;
    if (iss) begin
      issued_log.push_back(m_address);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (acc) begin
      c.addr = s_address; c.wdata = s_writedata; c.be = s_byteenable;
      c.burst = s_burstcount; c.rd = s_read; c.wr = s_write;
      exp_q.push_back(c);
    end
    rd_n = rd_m; wr_n = wr_m;
    if (acc && s_read)  rd_n += int'(s_burstcount);
    if (acc && s_write) wr_n += 1;
    if (m_readdatavalid      && rd_m > 0) rd_n -= 1;
    if (m_writeresponsevalid && wr_m > 0) wr_n -= 1;
    if ((m_readdatavalid && rd_m == 0) || (m_writeresponsevalid && wr_m == 0)) err_m = 1'b1;
    else if (clr_err) err_m = 1'b0;
    rd_m = rd_n; wr_m = wr_n;
    exp_rdv = m_readdatavalid; exp_wrv = m_writeresponsevalid; exp_rsp = m_response;
    if (m_readdatavalid) exp_rdata = m_readdata;
    @(posedge clk);
    @(negedge clk);

    total++;
    if (s_waitrequest !== ((exp_q.size() >= 2) || (rd_m > LIMIT))) begin
      bad++; $display("FAIL sb_waitrequest: got %b want %b (queued=%0d rd=%0d)", s_waitrequest,
                      (exp_q.size() >= 2) || (rd_m > LIMIT), exp_q.size(), rd_m);
    end
    total++;
    if ((m_read || m_write) !== (exp_q.size() > 0)) begin
      bad++; $display("FAIL sb_m_valid: got %b want %b", m_read || m_write, exp_q.size() > 0);
    end
    if (exp_q.size() > 0) begin
      total++;
      if (m_address !== exp_q[0].addr || m_writedata !== exp_q[0].wdata ||
          m_byteenable !== exp_q[0].be || m_burstcount !== exp_q[0].burst ||
          m_read !== exp_q[0].rd || m_write !== exp_q[0].wr) begin
        bad++; $display("FAIL sb_m_fields: got addr=%h rd=%b wr=%b want addr=%h rd=%b wr=%b",
                        m_address, m_read, m_write, exp_q[0].addr, exp_q[0].rd, exp_q[0].wr);
      end
    end
    total++;
    if (rd_pending !== CNT_W'(rd_m)) begin
      bad++; $display("FAIL sb_rd_pending: got %0d want %0d", rd_pending, rd_m);
    end
    total++;
    if (wr_pending !== CNT_W'(wr_m)) begin
      bad++; $display("FAIL sb_wr_pending: got %0d want %0d", wr_pending, wr_m);
    end
    total++;
    if (err_unexpected_rsp !== err_m) begin
      bad++; $display("FAIL sb_err: got %b want %b", err_unexpected_rsp, err_m);
    end
    total++;
    if (s_readdatavalid !== exp_rdv || s_writeresponsevalid !== exp_wrv || s_response !== exp_rsp) begin
      bad++; $display("FAIL sb_rsp: got rdv=%b wrv=%b rsp=%b want rdv=%b wrv=%b rsp=%b",
                      s_readdatavalid, s_writeresponsevalid, s_response, exp_rdv, exp_wrv, exp_rsp);
    end
    total++;
    if (s_readdata !== exp_rdata) begin
      bad++; $display("FAIL sb_readdata: got %h want %h", s_readdata, exp_rdata);
    end
  endtask

  // Return every outstanding response and let the command queue empty.
  task automatic drain();
    idle();
    m_waitrequest = 1'b0;
    for (int i = 0; i < 300 && (rd_m > 0 || wr_m > 0 || exp_q.size() > 0); i++) begin
      m_readdatavalid      = (rd_m > 0);
      m_writeresponsevalid = (wr_m > 0);
      m_response           = RSP_OKAY;
      m_readdata           = rand_data();
      tick();
    end
    idle();
    total++;
    if (rd_m != 0 || wr_m != 0 || exp_q.size() != 0) begin
      bad++; $display("FAIL drain_timeout: rd=%0d wr=%0d queued=%0d want all 0", rd_m, wr_m, exp_q.size());
    end
  endtask

  task automatic test_reset();
    model_reset();
    idle();
    @(negedge clk); @(negedge clk);
    total++;
    if (s_waitrequest !== 1'b1 || m_read !== 1'b0 || m_write !== 1'b0) begin
      bad++; $display("FAIL reset_strobes: got wait=%b rd=%b wr=%b want 1 0 0", s_waitrequest, m_read, m_write);
    end
    total++;
    if (rd_pending !== '0 || wr_pending !== '0 || err_unexpected_rsp !== 1'b0) begin
      bad++; $display("FAIL reset_counters: got rd=%0d wr=%0d err=%b want 0 0 0", rd_pending, wr_pending, err_unexpected_rsp);
    end
    total++;
    if (s_readdatavalid !== 1'b0 || s_writeresponsevalid !== 1'b0 || s_readdata !== '0) begin
      bad++; $display("FAIL reset_rsp: got rdv=%b wrv=%b want 0 0", s_readdatavalid, s_writeresponsevalid);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (s_waitrequest !== 1'b0) begin
      bad++; $display("FAIL reset_release: s_waitrequest got %b want 0 one edge after release", s_waitrequest);
    end
  endtask

  task automatic test_write();
    logic [DATA_W-1:0] pat;
    pat = {(DATA_W / 32){32'hA5A5_A5A5}};
    m_waitrequest = 1'b0;
    drive_cmd(1'b0, ADDR_W'(26'h0000040));
    s_writedata = pat;
    tick();
    s_write = 1'b0;
    total++;
    if (m_write !== 1'b1 || m_address !== ADDR_W'(26'h40) || m_writedata !== pat) begin
      bad++; $display("FAIL write_issue: got wr=%b addr=%h want 1 40", m_write, m_address);
    end
    tick();
    total++;
    if (m_write !== 1'b0 || wr_pending !== CNT_W'(1)) begin
      bad++; $display("FAIL write_once: got wr=%b wr_pending=%0d want 0 1", m_write, wr_pending);
    end
    m_writeresponsevalid = 1'b1; m_response = RSP_OKAY;
    tick();
    m_writeresponsevalid = 1'b0;
    total++;
    if (wr_pending !== '0 || s_writeresponsevalid !== 1'b1) begin
      bad++; $display("FAIL write_rsp: got wr_pending=%0d wrv=%b want 0 1", wr_pending, s_writeresponsevalid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n_acc;
    m_waitrequest = 1'b1;
    issued_log.delete();
    drive_cmd(1'b1, ADDR_W'(26'h10)); tick();
    drive_cmd(1'b1, ADDR_W'(26'h11)); tick();
    total++;
    if (s_waitrequest !== 1'b1 || m_read !== 1'b1 || m_address !== ADDR_W'(26'h10)) begin
      bad++; $display("FAIL b2b_skid_full: got wait=%b rd=%b addr=%h want 1 1 10", s_waitrequest, m_read, m_address);
    end
    drive_cmd(1'b1, ADDR_W'(26'h12));
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (last_acc) n_acc++;
    end
    total++;
    if (n_acc != 0) begin
      bad++; $display("FAIL b2b_stalled: got %0d accepts while full want 0", n_acc);
    end
    m_waitrequest = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) s_read = 1'b0;
    end
    total++;
    if (issued_log.size() != 3 || issued_log[0] !== ADDR_W'(26'h10) ||
        issued_log[1] !== ADDR_W'(26'h11) || issued_log[2] !== ADDR_W'(26'h12)) begin
      bad++; $display("FAIL b2b_order: got %0d issued (first %h) want 3 in order 10 11 12",
                      issued_log.size(), issued_log.size() > 0 ? issued_log[0] : '0);
    end
    drain();
  endtask

  task automatic test_read_limit();
    int n_acc;
    m_waitrequest = 1'b0;
    idle();
    n_acc = 0;
    for (int i = 0; i < 100; i++) begin
      drive_cmd(1'b1, ADDR_W'(i));
      tick();
      if (last_acc) n_acc++;
    end
    total++;
    if (n_acc != MAX_RD_BEATS || rd_pending !== CNT_W'(MAX_RD_BEATS) || s_waitrequest !== 1'b1) begin
      bad++; $display("FAIL limit_fill: got accepts=%0d rd_pending=%0d wait=%b want %0d %0d 1",
                      n_acc, rd_pending, s_waitrequest, MAX_RD_BEATS, MAX_RD_BEATS);
    end
    m_readdatavalid = 1'b1;
    tick();
    m_readdatavalid = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (last_acc) n_acc++;
    end
    total++;
    if (n_acc != 1 || rd_pending !== CNT_W'(MAX_RD_BEATS)) begin
      bad++; $display("FAIL limit_one_more: got accepts=%0d rd_pending=%0d want 1 %0d", n_acc, rd_pending, MAX_RD_BEATS);
    end
    drain();
  endtask

  task automatic test_unexpected();
    idle();
    m_writeresponsevalid = 1'b1;
    tick();
    m_writeresponsevalid = 1'b0;
    total++;
    if (err_unexpected_rsp !== 1'b1 || wr_pending !== '0) begin
      bad++; $display("FAIL unexp_set: got err=%b wr_pending=%0d want 1 0", err_unexpected_rsp, wr_pending);
    end
    m_readdatavalid = 1'b1; clr_err = 1'b1;
    tick();
    idle();
    total++;
    if (err_unexpected_rsp !== 1'b1 || rd_pending !== '0) begin
      bad++; $display("FAIL unexp_set_wins: got err=%b rd_pending=%0d want 1 0", err_unexpected_rsp, rd_pending);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    total++;
    if (err_unexpected_rsp !== 1'b0) begin
      bad++; $display("FAIL unexp_clear: got err=%b want 0", err_unexpected_rsp);
    end
  endtask

  task automatic test_response();
    logic [DATA_W-1:0] beef;
    beef = DATA_W'(32'hDEAD_BEEF);
    m_waitrequest = 1'b0;
    drive_cmd(1'b1, ADDR_W'(26'h20)); tick();
    drive_cmd(1'b1, ADDR_W'(26'h21));
    m_readdatavalid = 1'b1; m_readdata = beef; m_response = RSP_SLVERR;
    total++;
    if (s_readdatavalid !== 1'b0) begin
      bad++; $display("FAIL rsp_early: s_readdatavalid got %b want 0 before edge", s_readdatavalid);
    end
    tick();
    idle(); m_response = RSP_OKAY; m_readdata = rand_data();
    total++;
    if (s_readdatavalid !== 1'b1 || s_readdata !== beef || s_response !== RSP_SLVERR || rd_pending !== CNT_W'(1)) begin
      bad++; $display("FAIL rsp_delay: got rdv=%b data=%h rsp=%b rd_pending=%0d want 1 deadbeef 10 1",
                      s_readdatavalid, s_readdata[31:0], s_response, rd_pending);
    end
    tick();
    total++;
    if (s_readdatavalid !== 1'b0 || s_readdata !== beef) begin
      bad++; $display("FAIL rsp_hold: got rdv=%b data=%h want 0 deadbeef", s_readdatavalid, s_readdata[31:0]);
    end
    drain();
  endtask

  task automatic test_random();
    logic [1:0] codes [3];
    int r;
    codes[0] = RSP_OKAY; codes[1] = RSP_SLVERR; codes[2] = RSP_DECERR;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 3);
      drive_cmd(r == 1, ADDR_W'($urandom));
      s_read  = (r == 1);
      s_write = (r == 2);
      m_waitrequest        = ($urandom_range(0, 9) < 3);
      m_readdatavalid      = (rd_m > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      m_writeresponsevalid = (wr_m > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 49) == 0);
      m_readdata           = rand_data();
      m_response           = codes[$urandom_range(0, 2)];
      clr_err              = ($urandom_range(0, 19) == 0);
      tick();
    end
    drain();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_waitrequest = 1'b1;
    drive_cmd(1'b1, ADDR_W'(26'h30)); tick();
    drive_cmd(1'b1, ADDR_W'(26'h31)); tick();
    drive_cmd(1'b0, ADDR_W'(26'h32)); tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (m_read !== 1'b0 || m_write !== 1'b0 || s_waitrequest !== 1'b1 || rd_pending !== '0) begin
      bad++; $display("FAIL midreset: got rd=%b wr=%b wait=%b rd_pending=%0d want 0 0 1 0",
                      m_read, m_write, s_waitrequest, rd_pending);
    end
    model_reset();
    idle();
    m_waitrequest = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (s_waitrequest !== 1'b0) begin
      bad++; $display("FAIL midreset_release: s_waitrequest got %b want 0", s_waitrequest);
    end
    m_readdatavalid = 1'b1;
    tick();
    idle();
    total++;
    if (err_unexpected_rsp !== 1'b1) begin
      bad++; $display("FAIL midreset_late_rsp: err got %b want 1", err_unexpected_rsp);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_read_limit();
    test_unexpected();
    test_response();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
